prefetch_control_mt: RTL and testbench
======================================

# prefetch_control_mt

Parametrised instruction-prefetch controller between the prefetch unit, code TLB and icache. It clamps fetch length at page boundaries and issues icache read requests. It adds a small fully-associative micro-TLB of recent code-page translations, so page crossings and re-fetches that hit skip the TLB round trip. Thresholds, length width and page size are parameters.

## Interface
- ENTRIES, 2: micro-TLB entries (1..8).
- LEN_W, 5: width of prefetch/icache length; LEN_W <= PAGE_BITS.
- FIFO_W, 5: width of prefetchfifo_used.
- LOW_WATER, 3: new fetch sequence starts only if fifo_used < LOW_WATER.
- HIGH_WATER, 8: streaming stops when fifo_used >= HIGH_WATER.
- PAGE_BITS, 12: log2 page size.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pr_reset  in  1  prefetch restart; aborts fetch, invalidates micro-TLB.
- prefetch_address  in  32  linear fetch address.
- prefetch_length  in  LEN_W  bytes wanted (0 = none).
- prefetch_su  in  1  privilege of fetch.
- prefetchfifo_used  in  FIFO_W  prefetch FIFO occupancy.
- tlbcoderequest_do  out  1  TLB translation request, held until tlbcode_do.
- tlbcoderequest_address  out  32  = prefetch_address.
- tlbcoderequest_su  out  1  = prefetch_su.
- tlbcode_do  in  1  translation done (single-cycle pulse).
- tlbcode_linear / tlbcode_physical  in  32 each  translated pair.
- tlbcode_cache_disable  in  1  page uncacheable.
- icacheread_do  out  1  icache read request this cycle.
- icacheread_address  out  32  physical address.
- icacheread_length  out  LEN_W  clamped length.
- icacheread_cache_disable  out  1  from entry in use.

## Operation
- Outputs are combinational from state, current entry and inputs.
- len = min(prefetch_length, 2^PAGE_BITS - offset), offset = prefetch_address[PAGE_BITS-1:0]; compare at PAGE_BITS+1 bits; result truncated to LEN_W.
- Hit: valid entry whose page tag equals prefetch_address[31:PAGE_BITS] and whose su equals prefetch_su. At most one entry hits (fill never duplicates a tag/su pair).
- go = ~pr_reset && prefetch_length != 0 && prefetchfifo_used < LOW_WATER.
- State TLB_REQUEST (reset state):
  - go and hit: icacheread_do=1, address {entry.phys_page, offset}, length len, cache_disable from entry; current entry <= hit index; -> ICACHE.
  - go and miss: tlbcoderequest_do=1. When tlbcode_do: fill entry at round-robin pointer (tag, phys page, cache_disable, su, valid), pointer++ (wrap at ENTRIES), current <= that entry; icacheread_do=1 with {tlbcode_physical page, offset}, tlbcode_cache_disable; -> ICACHE.
  - tlbcode_do with tlbcoderequest_do low is ignored (no fill).
- State ICACHE:
  - pr_reset or fifo_used >= HIGH_WATER: icacheread_do=0; -> TLB_REQUEST.
  - Same page as current entry: icacheread_do=1 (when prefetch_length != 0) from current entry.
  - Page cross with hit on another entry: current <= hit; icacheread_do=1 same cycle; stay.
  - Page cross miss: icacheread_do=0; -> TLB_REQUEST.
- pr_reset in any state: all valid bits cleared next edge, pointer to 0, state TLB_REQUEST; beats go/tlbcode_do.

## Timing
- Reset: state TLB_REQUEST, valid all 0, pointer 0, current 0; every output 0 (request/address outputs follow inputs but _do strobes are 0 while prefetch_length=0 or pr_reset).
- Hit latency: 0 cycles (icacheread_do in cycle go first true).
- Miss latency: icacheread_do in the tlbcode_do cycle.
- Page-cross hit while streaming: no bubble; miss: at least 1 bubble plus TLB latency.
- icacheread_do single-cycle per cycle of request; icache accepts every cycle.

## Structure
- Shared package: state encodings (TLB_REQUEST=0, ICACHE=1), entry struct width helper, length-clamp function.
- Sub-module prefetch_utlb: ENTRIES-deep valid/tag/phys/cd/su array, combinational lookup (hit, index, phys, cd), fill port, round-robin pointer, flush input.

## Test plan
- Reset then address 0x0000_1FF0, length 16, fifo 0, miss: tlbcoderequest_do=1 until tlbcode_do(phys 0x0040_0000) -> same cycle icacheread_do, address 0x0040_0FF0, length 16.
- Address 0x0000_1FFC, length 16 -> length clamped to 4.
- Streaming then cross to page 0x2 (miss) -> state TLB_REQUEST, new request; return to page 0x1 -> hit, icacheread_do without tlbcoderequest_do.
- ENTRIES=2, fill pages 1,2,3 -> page 1 evicted (miss), page 3 hits.
- fifo_used=8 in ICACHE -> icacheread_do=0, TLB_REQUEST; resume only when fifo_used<3.
- pr_reset coincident with tlbcode_do -> no icacheread_do, all entries invalid, next fetch misses.

Source files
------------

// File: rtl/prefetch_control_mt_pkg.sv
// Shared types and helpers for the instruction-prefetch controller and its micro-TLB.
package prefetch_control_mt_pkg;

  typedef enum logic {
    TLB_REQUEST = 1'b0,
    ICACHE      = 1'b1
  } state_e;

  // Packed micro-TLB entry: {valid, su, cache_disable, phys_page, tag}
  function automatic int unsigned utlbEntryBits(input int unsigned pageBits);
    return 2 * (32 - pageBits) + 3;
  endfunction

  // Bytes that can be fetched without leaving the page; compared one bit wider than the page
  function automatic logic [31:0] clampLen(input logic [31:0] len,
                                           input logic [31:0] offset,
                                           input int unsigned pageBits);
    logic [32:0] room;
    logic [31:0] result;
    room = (33'd1 << pageBits) - {1'b0, offset};
    if ({1'b0, len} < room) result = len;
    else result = room[31:0];
    return result;
  endfunction

endpackage

// File: rtl/prefetch_control_mt_if.sv
// Prefetch-unit, code-TLB and icache signals seen by the prefetch controller.
interface prefetch_control_mt_if #(
  parameter int LEN_W  = 5,
  parameter int FIFO_W = 5
);
  logic              pr_reset;
  logic [31:0]       prefetch_address;
  logic [LEN_W-1:0]  prefetch_length;
  logic              prefetch_su;
  logic [FIFO_W-1:0] prefetchfifo_used;

  logic              tlbcoderequest_do;
  logic [31:0]       tlbcoderequest_address;
  logic              tlbcoderequest_su;
  logic              tlbcode_do;
  logic [31:0]       tlbcode_linear;
  logic [31:0]       tlbcode_physical;
  logic              tlbcode_cache_disable;

  logic              icacheread_do;
  logic [31:0]       icacheread_address;
  logic [LEN_W-1:0]  icacheread_length;
  logic              icacheread_cache_disable;

  // The controller issues TLB and icache requests
  modport master (
    input  pr_reset, prefetch_address, prefetch_length, prefetch_su, prefetchfifo_used,
    input  tlbcode_do, tlbcode_linear, tlbcode_physical, tlbcode_cache_disable,
    output tlbcoderequest_do, tlbcoderequest_address, tlbcoderequest_su,
    output icacheread_do, icacheread_address, icacheread_length, icacheread_cache_disable
  );

  modport slave (
    output pr_reset, prefetch_address, prefetch_length, prefetch_su, prefetchfifo_used,
    output tlbcode_do, tlbcode_linear, tlbcode_physical, tlbcode_cache_disable,
    input  tlbcoderequest_do, tlbcoderequest_address, tlbcoderequest_su,
    input  icacheread_do, icacheread_address, icacheread_length, icacheread_cache_disable
  );
endinterface

// File: rtl/prefetch_control_mt_utlb.sv
// Fully-associative micro-TLB of recent code-page translations with round-robin replacement.
module prefetch_utlb
  import prefetch_control_mt_pkg::*;
#(
  parameter int ENTRIES   = 2,
  parameter int PAGE_BITS = 12,
  localparam int IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int TAG_W    = 32 - PAGE_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [TAG_W-1:0] lookupTag_i,
  input  logic             lookupSu_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] hitIdx_o,
  output logic [TAG_W-1:0] hitPhys_o,
  output logic             hitCd_o,
  input  logic [IDX_W-1:0] curIdx_i,
  output logic             curValid_o,
  output logic [TAG_W-1:0] curTag_o,
  output logic [TAG_W-1:0] curPhys_o,
  output logic             curSu_o,
  output logic             curCd_o,
  input  logic             fill_i,
  input  logic [TAG_W-1:0] fillTag_i,
  input  logic [TAG_W-1:0] fillPhys_i,
  input  logic             fillCd_i,
  input  logic             fillSu_i,
  output logic [IDX_W-1:0] fillIdx_o
);

  localparam int EW        = utlbEntryBits(PAGE_BITS);
  localparam int CD_BIT    = 2 * TAG_W;
  localparam int SU_BIT    = 2 * TAG_W + 1;
  localparam int VALID_BIT = 2 * TAG_W + 2;

  logic [EW-1:0]    entries_q [ENTRIES];
  logic [IDX_W-1:0] ptr_q;
  logic [EW-1:0]    curEntry;

  assign fillIdx_o = ptr_q;

  // Fills only ever happen on a miss, so at most one entry can match
  always_comb begin
    hit_o     = 1'b0;
    hitIdx_o  = '0;
    hitPhys_o = '0;
    hitCd_o   = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entries_q[i][VALID_BIT] && (entries_q[i][SU_BIT] == lookupSu_i) &&
          (entries_q[i][TAG_W-1:0] == lookupTag_i)) begin
        hit_o     = 1'b1;
        hitIdx_o  = IDX_W'(i);
        hitPhys_o = entries_q[i][2*TAG_W-1:TAG_W];
        hitCd_o   = entries_q[i][CD_BIT];
      end
    end
  end

  assign curEntry   = entries_q[curIdx_i];
  assign curValid_o = curEntry[VALID_BIT];
  assign curSu_o    = curEntry[SU_BIT];
  assign curCd_o    = curEntry[CD_BIT];
  assign curPhys_o  = curEntry[2*TAG_W-1:TAG_W];
  assign curTag_o   = curEntry[TAG_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
    end else if (flush_i) begin
      ptr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
    end else if (fill_i) begin
      entries_q[ptr_q] <= {1'b1, fillSu_i, fillCd_i, fillPhys_i, fillTag_i};
      ptr_q <= (ptr_q == IDX_W'(ENTRIES - 1)) ? '0 : ptr_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/prefetch_control_mt.sv
// Instruction-prefetch controller: clamps fetches at page ends and issues icache reads via a micro-TLB.
module prefetch_control_mt
  import prefetch_control_mt_pkg::*;
#(
  parameter int ENTRIES    = 2,
  parameter int LEN_W      = 5,
  parameter int FIFO_W     = 5,
  parameter int LOW_WATER  = 3,
  parameter int HIGH_WATER = 8,
  parameter int PAGE_BITS  = 12
) (
  input logic clk,
  input logic rst_n,
  prefetch_control_mt_if.master bus
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int TAG_W = 32 - PAGE_BITS;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] curIdx_q, curIdx_d;

  logic [PAGE_BITS-1:0] offset;
  logic [TAG_W-1:0]     pageTag;
  logic [LEN_W-1:0]     len;
  logic                 lenNonZero, go, fifoHigh, samePage;

  logic             hit, curValid, curSu, curCd, hitCd, fill;
  logic [IDX_W-1:0] hitIdx, fillIdx;
  logic [TAG_W-1:0] hitPhys, curTag, curPhys;
  logic             unusedLowBits;

  assign offset     = bus.prefetch_address[PAGE_BITS-1:0];
  assign pageTag    = bus.prefetch_address[31:PAGE_BITS];
  assign len        = LEN_W'(clampLen(32'(bus.prefetch_length), 32'(offset), PAGE_BITS));
  assign lenNonZero = (bus.prefetch_length != '0);
  assign go         = !bus.pr_reset && lenNonZero && (32'(bus.prefetchfifo_used) < LOW_WATER);
  assign fifoHigh   = (32'(bus.prefetchfifo_used) >= HIGH_WATER);
  assign samePage   = curValid && (curTag == pageTag) && (curSu == bus.prefetch_su);

  assign bus.tlbcoderequest_address = bus.prefetch_address;
  assign bus.tlbcoderequest_su      = bus.prefetch_su;

  assign unusedLowBits = ^{bus.tlbcode_linear[PAGE_BITS-1:0], bus.tlbcode_physical[PAGE_BITS-1:0]};

  prefetch_utlb #(
    .ENTRIES  (ENTRIES),
    .PAGE_BITS(PAGE_BITS)
  ) uUtlb (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (bus.pr_reset),
    .lookupTag_i(pageTag),
    .lookupSu_i (bus.prefetch_su),
    .hit_o      (hit),
    .hitIdx_o   (hitIdx),
    .hitPhys_o  (hitPhys),
    .hitCd_o    (hitCd),
    .curIdx_i   (curIdx_q),
    .curValid_o (curValid),
    .curTag_o   (curTag),
    .curPhys_o  (curPhys),
    .curSu_o    (curSu),
    .curCd_o    (curCd),
    .fill_i     (fill),
    .fillTag_i  (bus.tlbcode_linear[31:PAGE_BITS]),
    .fillPhys_i (bus.tlbcode_physical[31:PAGE_BITS]),
    .fillCd_i   (bus.tlbcode_cache_disable),
    .fillSu_i   (bus.prefetch_su),
    .fillIdx_o  (fillIdx)
  );

  // Request strobes and next state; a page cross that hits keeps streaming without a bubble
  always_comb begin
    state_d                      = state_q;
    curIdx_d                     = curIdx_q;
    fill                         = 1'b0;
    bus.tlbcoderequest_do        = 1'b0;
    bus.icacheread_do            = 1'b0;
    bus.icacheread_address       = '0;
    bus.icacheread_length        = '0;
    bus.icacheread_cache_disable = 1'b0;
    if (bus.pr_reset) begin
      state_d  = TLB_REQUEST;
      curIdx_d = '0;
    end else begin
      case (state_q)
        TLB_REQUEST: begin
          if (go && hit) begin
            bus.icacheread_do            = 1'b1;
            bus.icacheread_address       = {hitPhys, offset};
            bus.icacheread_length        = len;
            bus.icacheread_cache_disable = hitCd;
            curIdx_d                     = hitIdx;
            state_d                      = ICACHE;
          end else if (go) begin
            bus.tlbcoderequest_do = 1'b1;
            if (bus.tlbcode_do) begin
              fill                         = 1'b1;
              bus.icacheread_do            = 1'b1;
              bus.icacheread_address       = {bus.tlbcode_physical[31:PAGE_BITS], offset};
              bus.icacheread_length        = len;
              bus.icacheread_cache_disable = bus.tlbcode_cache_disable;
              curIdx_d                     = fillIdx;
              state_d                      = ICACHE;
            end
          end
        end
        ICACHE: begin
          if (fifoHigh) begin
            state_d = TLB_REQUEST;
          end else if (lenNonZero) begin
            if (samePage) begin
              bus.icacheread_do            = 1'b1;
              bus.icacheread_address       = {curPhys, offset};
              bus.icacheread_length        = len;
              bus.icacheread_cache_disable = curCd;
            end else if (hit) begin
              bus.icacheread_do            = 1'b1;
              bus.icacheread_address       = {hitPhys, offset};
              bus.icacheread_length        = len;
              bus.icacheread_cache_disable = hitCd;
              curIdx_d                     = hitIdx;
            end else begin
              state_d = TLB_REQUEST;
            end
          end
        end
        default: state_d = TLB_REQUEST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TLB_REQUEST;
      curIdx_q <= '0;
    end else begin
      state_q  <= state_d;
      curIdx_q <= curIdx_d;
    end
  end

endmodule

// File: tb/tb_prefetch_control_mt.sv
// Directed bench for prefetch_control_mt: miss/hit paths, page clamping, eviction, watermarks and restart.
module tb_prefetch_control_mt;
  localparam int LEN_W  = 5;
  localparam int FIFO_W = 5;

  logic clk;
  logic rst_n;
  int   nAsserts = 0;
  int   nFails   = 0;

  prefetch_control_mt_if #(.LEN_W(LEN_W), .FIFO_W(FIFO_W)) bus ();

  prefetch_control_mt #(
    .ENTRIES   (2),
    .LEN_W     (LEN_W),
    .FIFO_W    (FIFO_W),
    .LOW_WATER (3),
    .HIGH_WATER(8),
    .PAGE_BITS (12)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge so outputs settle well before the next rising edge
  task automatic applyStimulus(input logic [31:0] addr, input int len, input logic su,
                               input int fifo, input logic prReset);
    bus.prefetch_address  = addr;
    bus.prefetch_length   = LEN_W'(len);
    bus.prefetch_su       = su;
    bus.prefetchfifo_used = FIFO_W'(fifo);
    bus.pr_reset          = prReset;
  endtask

  task automatic applyTlb(input logic done, input logic [31:0] linear, input logic [31:0] phys,
                          input logic cd);
    bus.tlbcode_do            = done;
    bus.tlbcode_linear        = linear;
    bus.tlbcode_physical      = phys;
    bus.tlbcode_cache_disable = cd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkStrobes(input string tag, input logic tlbReq, input logic icDo);
    checkOutput({tag, ".tlbreq"}, 32'(bus.tlbcoderequest_do), 32'(tlbReq));
    checkOutput({tag, ".icdo"}, 32'(bus.icacheread_do), 32'(icDo));
  endtask

  task automatic checkRead(input string tag, input logic [31:0] addr, input int len,
                           input logic cd);
    checkOutput({tag, ".icdo"}, 32'(bus.icacheread_do), 32'd1);
    checkOutput({tag, ".addr"}, bus.icacheread_address, addr);
    checkOutput({tag, ".len"}, 32'(bus.icacheread_length), 32'(len));
    checkOutput({tag, ".cd"}, 32'(bus.icacheread_cache_disable), 32'(cd));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(32'h0, 0, 1'b0, 0, 1'b0);
    applyTlb(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    checkStrobes("reset", 1'b0, 1'b0);
    checkOutput("reset.addr", bus.icacheread_address, 32'h0);
    checkOutput("reset.len", 32'(bus.icacheread_length), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold miss on page 1, translation arrives two cycles later
    @(negedge clk);
    applyStimulus(32'h0000_1FF0, 16, 1'b0, 0, 1'b0);
    #1;
    checkStrobes("miss1.wait0", 1'b1, 1'b0);
    checkOutput("miss1.reqaddr", bus.tlbcoderequest_address, 32'h0000_1FF0);
    @(negedge clk);
    #1;
    checkStrobes("miss1.wait1", 1'b1, 1'b0);
    @(negedge clk);
    applyTlb(1'b1, 32'h0000_1000, 32'h0040_0000, 1'b0);
    #1;
    checkOutput("miss1.tlbreq", 32'(bus.tlbcoderequest_do), 32'd1);
    checkRead("miss1.read", 32'h0040_0FF0, 16, 1'b0);

    // Same page, length clamped to the 4 bytes left in the page
    @(negedge clk);
    applyTlb(1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(32'h0000_1FFC, 16, 1'b0, 0, 1'b0);
    #1;
    checkOutput("clamp.tlbreq", 32'(bus.tlbcoderequest_do), 32'd0);
    checkRead("clamp.read", 32'h0040_0FFC, 4, 1'b0);

    // Cross to page 2 misses: bubble, then a fresh TLB request
    @(negedge clk);
    applyStimulus(32'h0000_2000, 16, 1'b0, 0, 1'b0);
    #1;
    checkStrobes("cross2.bubble", 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkStrobes("cross2.req", 1'b1, 1'b0);
    @(negedge clk);
    applyTlb(1'b1, 32'h0000_2000, 32'h0080_0000, 1'b1);
    #1;
    checkRead("cross2.read", 32'h0080_0000, 16, 1'b1);

    // Back to page 1 while streaming: hit, no bubble, no TLB request
    @(negedge clk);
    applyTlb(1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(32'h0000_1010, 8, 1'b0, 0, 1'b0);
    #1;
    checkOutput("back1.tlbreq", 32'(bus.tlbcoderequest_do), 32'd0);
    checkRead("back1.read", 32'h0040_0010, 8, 1'b0);

    // FIFO at high water stops streaming; resume only below low water
    @(negedge clk);
    applyStimulus(32'h0000_1010, 8, 1'b0, 8, 1'b0);
    #1;
    checkStrobes("high.stop", 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0000_1010, 8, 1'b0, 5, 1'b0);
    #1;
    checkStrobes("high.hold", 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0000_1010, 8, 1'b0, 2, 1'b0);
    #1;
    checkOutput("high.resume.tlbreq", 32'(bus.tlbcoderequest_do), 32'd0);
    checkRead("high.resume", 32'h0040_0010, 8, 1'b0);

    // Page 3 fill replaces the oldest entry (page 1)
    @(negedge clk);
    applyStimulus(32'h0000_3000, 16, 1'b0, 0, 1'b0);
    #1;
    checkStrobes("fill3.bubble", 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkStrobes("fill3.req", 1'b1, 1'b0);
    @(negedge clk);
    applyTlb(1'b1, 32'h0000_3000, 32'h00C0_0000, 1'b0);
    #1;
    checkRead("fill3.read", 32'h00C0_0000, 16, 1'b0);

    @(negedge clk);
    applyTlb(1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(32'h0000_1000, 4, 1'b0, 0, 1'b0);
    #1;
    checkStrobes("evict1.bubble", 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkStrobes("evict1.miss", 1'b1, 1'b0);

    // A supervisor fetch does not hit a user translation of the same page
    @(negedge clk);
    applyStimulus(32'h0000_3004, 16, 1'b1, 0, 1'b0);
    #1;
    checkStrobes("su.miss", 1'b1, 1'b0);
    checkOutput("su.reqsu", 32'(bus.tlbcoderequest_su), 32'd1);
    @(negedge clk);
    applyStimulus(32'h0000_3004, 16, 1'b0, 0, 1'b0);
    #1;
    checkOutput("hit3.tlbreq", 32'(bus.tlbcoderequest_do), 32'd0);
    checkRead("hit3.read", 32'h00C0_0004, 16, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0000_2008, 16, 1'b0, 0, 1'b0);
    #1;
    checkRead("hit2.read", 32'h0080_0008, 16, 1'b1);

    // Restart coincident with translation done: nothing issued, micro-TLB flushed
    @(negedge clk);
    applyStimulus(32'h0000_5000, 16, 1'b0, 0, 1'b0);
    #1;
    checkStrobes("rst5.bubble", 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkStrobes("rst5.req", 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0000_5000, 16, 1'b0, 0, 1'b1);
    applyTlb(1'b1, 32'h0000_5000, 32'h0140_0000, 1'b0);
    #1;
    checkStrobes("rst5.prreset", 1'b0, 1'b0);

    // Translation done without a pending request is ignored
    @(negedge clk);
    applyStimulus(32'h0000_7000, 0, 1'b0, 0, 1'b0);
    applyTlb(1'b1, 32'h0000_7000, 32'h00A0_0000, 1'b0);
    #1;
    checkStrobes("stray.done", 1'b0, 1'b0);
    @(negedge clk);
    applyTlb(1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(32'h0000_3004, 4, 1'b0, 0, 1'b0);
    #1;
    checkStrobes("flushed.miss3", 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0000_7000, 4, 1'b0, 0, 1'b0);
    #1;
    checkStrobes("stray.nofill", 1'b1, 1'b0);
    @(negedge clk);
    applyTlb(1'b1, 32'h0000_7000, 32'h00A0_0000, 1'b0);
    #1;
    checkRead("fill7.read", 32'h00A0_0000, 4, 1'b0);
    @(negedge clk);
    applyTlb(1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(32'h0000_0000, 0, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
